// File: rtl/audio_pkg.sv
// Shared audio-chain types and constants: sample format and I2S frame geometry.
// Also holds the slot-to-bit mapping used by the I2S serializer.
package audio_pkg;
   localparam int SAMPLE_W  = 16;
   localparam int I2S_SLOTS = 32;
   localparam int SLOT_W    = $clog2(I2S_SLOTS);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Bit driven while in slot s. Slot 0 is evaluated before cur_word is reloaded,
   // so w[0] there is still the previous frame's right-channel LSB.
   function automatic logic slot_bit(input sample_t w, input logic [SLOT_W-1:0] s);
      logic [SLOT_W-1:0] k;
      k = s - 1'b1;
      if (s == '0) begin
         return w[0];
      end
      return w[4'd15 - k[3:0]];
   endfunction
endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles i2s_bclk every CLK_DIV clk cycles, no backpressure.
// fall is combinational from state and marks the clk edge on which i2s_bclk drops.
module i2s_bclk_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic i2s_bclk,
   output logic fall
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CNT_W-1:0] div_cnt;
   logic             wrap;

   assign wrap = (div_cnt == CNT_W'(CLK_DIV - 1));
   assign fall = wrap && i2s_bclk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt  <= '0;
         i2s_bclk <= 1'b0;
      end else if (wrap) begin
         div_cnt  <= '0;
         i2s_bclk <= ~i2s_bclk;
      end else begin
         div_cnt  <= div_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/i2s_tx.sv
// Mono-to-stereo Philips I2S transmitter; left MSB appears 2*CLK_DIV cycles after frame load.
// One-word holding buffer: din_ready is low while it is full, freed at each frame load.
module i2s_tx
   import audio_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SAMPLE_W-1:0] din,
   input  logic                din_valid,
   output logic                din_ready,
   output logic                sample_tick,
   output logic                underrun,
   output logic                i2s_bclk,
   output logic                i2s_lrclk,
   output logic                i2s_sdata
);
   logic [SLOT_W-1:0] slot;
   logic [SLOT_W-1:0] next_slot;
   sample_t           cur_word;
   sample_t           buf_word;
   logic              fall;
   logic              load;
   logic              accept;

   i2s_bclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_bclk_gen (
      .clk      (clk),
      .rst      (rst),
      .i2s_bclk (i2s_bclk),
      .fall     (fall)
   );

   assign next_slot = slot + 1'b1;
   assign load      = fall && (next_slot == '0);
   assign accept    = din_valid && din_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot        <= SLOT_W'(I2S_SLOTS - 1);
         cur_word    <= '0;
         buf_word    <= '0;
         din_ready   <= 1'b1;
         sample_tick <= 1'b0;
         underrun    <= 1'b0;
         i2s_lrclk   <= 1'b0;
         i2s_sdata   <= 1'b0;
      end else begin
         sample_tick <= load;
         underrun    <= load && din_ready;

         if (fall) begin
            slot      <= next_slot;
            i2s_lrclk <= next_slot[SLOT_W-1];
            i2s_sdata <= slot_bit(cur_word, next_slot);
         end

         // Load takes priority; a word offered on the load edge lands in the freshly
         // emptied buffer only when the buffer was already empty (din_ready high).
         if (load && !din_ready) begin
            cur_word  <= buf_word;
            din_ready <= 1'b1;
         end else if (accept) begin
            buf_word  <= din;
            din_ready <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: one instance at CLK_DIV=4 for framing/handshake, one at CLK_DIV=2 for timing.
module tb_i2s_tx;
   localparam int DIV_A = 4;
   localparam int DIV_B = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a = 1'b1, din_valid_a = 1'b0;
   logic [15:0] din_a = '0;
   logic        din_ready_a, tick_a, underrun_a, bclk_a, lrclk_a, sdata_a;
   logic        rst_b = 1'b1, din_valid_b = 1'b0;
   logic [15:0] din_b = '0;
   logic        din_ready_b, tick_b, underrun_b, bclk_b, lrclk_b, sdata_b;

   i2s_tx #(.CLK_DIV(DIV_A)) dut_a (
      .clk(clk), .rst(rst_a), .din(din_a), .din_valid(din_valid_a), .din_ready(din_ready_a),
      .sample_tick(tick_a), .underrun(underrun_a), .i2s_bclk(bclk_a), .i2s_lrclk(lrclk_a),
      .i2s_sdata(sdata_a));

   i2s_tx #(.CLK_DIV(DIV_B)) dut_b (
      .clk(clk), .rst(rst_b), .din(din_b), .din_valid(din_valid_b), .din_ready(din_ready_b),
      .sample_tick(tick_b), .underrun(underrun_b), .i2s_bclk(bclk_b), .i2s_lrclk(lrclk_b),
      .i2s_sdata(sdata_b));

   int pass_cnt = 0;
   int total_cnt = 0;

   // Expected slot stream, slot 0 in the MSB: prev LSB, left w[15:0], right w[15:1].
   function automatic logic [31:0] frame_bits(input logic [15:0] w, input logic prev_lsb);
      return {prev_lsb, w, w[15:1]};
   endfunction

   localparam logic [31:0] LR_EXP = 32'h0000_FFFF;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic reset_a();
      rst_a = 1'b1;
      din_valid_a = 1'b0;
      step();
      step();
      rst_a = 1'b0;
   endtask

   task automatic wait_tick_a(input int limit, output int n);
      n = 0;
      while (!tick_a && n < limit) begin
         step();
         n++;
      end
   endtask

   // Called on the sample_tick cycle; samples each slot on its first cycle and ends on the next tick.
   task automatic capture_a(output logic [31:0] sd, output logic [31:0] lr, output int ticks,
                            output int unds, output logic und0, output logic rdy1);
      sd = '0; lr = '0; ticks = 0; unds = 0; und0 = underrun_a; rdy1 = 1'b0;
      for (int s = 0; s < 32; s++) begin
         sd = {sd[30:0], sdata_a};
         lr = {lr[30:0], lrclk_a};
         for (int c = 0; c < 2 * DIV_A; c++) begin
            if (tick_a) ticks++;
            if (underrun_a) unds++;
            step();
            if (s == 0 && c == 0) begin
               din_valid_a = 1'b0;
               rdy1 = din_ready_a;
            end
         end
      end
   endtask

   task automatic test_reset();
      int n;
      logic [31:0] sd, lr;
      int ticks, unds;
      logic und0, rdy1;
      rst_a = 1'b1;
      step();
      total_cnt++;
      if ({bclk_a, lrclk_a, sdata_a, din_ready_a, tick_a, underrun_a} !== 6'b000100)
         $display("FAIL reset_hold: got %b want 000100",
                  {bclk_a, lrclk_a, sdata_a, din_ready_a, tick_a, underrun_a});
      else pass_cnt++;
      rst_a = 1'b0;
      din_a = 16'hFFFF;
      din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      repeat (8 + 8 * 20 - 1) step();
      din_a = 16'h7777;
      din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      total_cnt++;
      if ({lrclk_a, sdata_a, din_ready_a} !== 3'b110)
         $display("FAIL midframe_state: got %b want 110", {lrclk_a, sdata_a, din_ready_a});
      else pass_cnt++;
      rst_a = 1'b1;
      step();
      total_cnt++;
      if ({bclk_a, lrclk_a, sdata_a, din_ready_a, tick_a, underrun_a} !== 6'b000100)
         $display("FAIL reset_midframe: got %b want 000100",
                  {bclk_a, lrclk_a, sdata_a, din_ready_a, tick_a, underrun_a});
      else pass_cnt++;
      step();
      rst_a = 1'b0;
      n = 0;
      while (!bclk_a && n < 20) begin
         step();
         n++;
      end
      total_cnt++;
      if (n !== DIV_A) $display("FAIL first_bclk_rise: got %0d cycles want %0d", n, DIV_A);
      else pass_cnt++;
      wait_tick_a(40, n);
      total_cnt++;
      if (!tick_a || n !== DIV_A)
         $display("FAIL first_load: tick=%b after %0d more cycles want 1 after %0d", tick_a, n, DIV_A);
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0} !== {32'h0, 1'b1})
         $display("FAIL no_replay: got sd=%h und=%b want 00000000 und=1", sd, und0);
      else pass_cnt++;
   endtask

   task automatic test_single_word();
      int n;
      logic [31:0] sd, lr;
      int ticks, unds;
      logic und0, rdy1;
      reset_a();
      din_a = 16'hA5F0;
      din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      wait_tick_a(40, n);
      total_cnt++;
      if (!tick_a || n !== 2 * DIV_A - 1)
         $display("FAIL load_latency: tick=%b at %0d want 1 at %0d", tick_a, n, 2 * DIV_A - 1);
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if (sd[30:15] !== 16'b1010010111110000)
         $display("FAIL left_slots: got %b want 1010010111110000", sd[30:15]);
      else pass_cnt++;
      total_cnt++;
      if (sd[14:0] !== 15'b101001011111000)
         $display("FAIL right_slots: got %b want 101001011111000", sd[14:0]);
      else pass_cnt++;
      total_cnt++;
      if (sd[31] !== 1'b0) $display("FAIL slot0_first: got %b want 0", sd[31]);
      else pass_cnt++;
      total_cnt++;
      if (lr !== LR_EXP) $display("FAIL lrclk_pattern: got %h want %h", lr, LR_EXP);
      else pass_cnt++;
      total_cnt++;
      if ({und0, ticks} !== {1'b0, 32'd1})
         $display("FAIL single_tick: und=%b ticks=%0d want und=0 ticks=1", und0, ticks);
      else pass_cnt++;
      total_cnt++;
      if ({tick_a, sdata_a} !== 2'b10)
         $display("FAIL next_slot0: tick=%b sdata=%b want tick=1 sdata=0", tick_a, sdata_a);
      else pass_cnt++;
   endtask

   task automatic test_underrun();
      int n;
      logic [31:0] sd, lr;
      int ticks, unds;
      logic und0, rdy1;
      reset_a();
      din_a = 16'h8001;
      din_valid_a = 1'b1;
      step();
      din_valid_a = 1'b0;
      wait_tick_a(40, n);
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0} !== {frame_bits(16'h8001, 1'b0), 1'b0})
         $display("FAIL underrun_f1: got %h und=%b want %h und=0", sd, und0, frame_bits(16'h8001, 1'b0));
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if (sd !== frame_bits(16'h8001, 1'b1))
         $display("FAIL underrun_repeat: got %h want %h", sd, frame_bits(16'h8001, 1'b1));
      else pass_cnt++;
      total_cnt++;
      if ({und0, unds, ticks} !== {1'b1, 32'd1, 32'd1})
         $display("FAIL underrun_pulse_f2: und0=%b unds=%0d ticks=%0d want 1/1/1", und0, unds, ticks);
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({und0, unds, ticks} !== {1'b1, 32'd1, 32'd1})
         $display("FAIL underrun_pulse_f3: und0=%b unds=%0d ticks=%0d want 1/1/1", und0, unds, ticks);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n, ready_hi;
      logic [31:0] sd, lr;
      int ticks, unds;
      logic und0, rdy1;
      reset_a();
      din_a = 16'h1234;
      din_valid_a = 1'b1;
      step();
      din_a = 16'hFFFF;
      n = 0;
      ready_hi = 0;
      while (!tick_a && n < 40) begin
         if (din_ready_a) ready_hi++;
         step();
         n++;
      end
      total_cnt++;
      if (ready_hi !== 0) $display("FAIL b2b_ready_low: ready high %0d cycles want 0", ready_hi);
      else pass_cnt++;
      total_cnt++;
      if ({tick_a, din_ready_a} !== 2'b11)
         $display("FAIL b2b_ready_on_load: tick=%b ready=%b want 11", tick_a, din_ready_a);
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0, rdy1} !== {frame_bits(16'h1234, 1'b0), 2'b00})
         $display("FAIL b2b_f1: got %h und=%b rdy=%b want %h und=0 rdy=0", sd, und0, rdy1,
                  frame_bits(16'h1234, 1'b0));
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0} !== {frame_bits(16'hFFFF, 1'b0), 1'b0})
         $display("FAIL b2b_f2: got %h und=%b want %h und=0", sd, und0, frame_bits(16'hFFFF, 1'b0));
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0} !== {frame_bits(16'hFFFF, 1'b1), 1'b1})
         $display("FAIL b2b_f3: got %h und=%b want %h und=1", sd, und0, frame_bits(16'hFFFF, 1'b1));
      else pass_cnt++;
   endtask

   task automatic test_accept_on_load();
      int n;
      logic [31:0] sd, lr;
      int ticks, unds;
      logic und0, rdy1;
      reset_a();
      din_a = 16'h3C5A;
      wait_tick_a(40, n);
      din_valid_a = 1'b1;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0, rdy1} !== {32'h0, 2'b10})
         $display("FAIL aol_f1: got %h und=%b rdy=%b want 00000000 und=1 rdy=0", sd, und0, rdy1);
      else pass_cnt++;
      capture_a(sd, lr, ticks, unds, und0, rdy1);
      total_cnt++;
      if ({sd, und0} !== {frame_bits(16'h3C5A, 1'b0), 1'b0})
         $display("FAIL aol_f2: got %h und=%b want %h und=0", sd, und0, frame_bits(16'h3C5A, 1'b0));
      else pass_cnt++;
   endtask

   task automatic test_clk_div2();
      int n, p;
      rst_b = 1'b1;
      step();
      step();
      rst_b = 1'b0;
      n = 0;
      while (!bclk_b && n < 20) begin
         step();
         n++;
      end
      total_cnt++;
      if (n !== DIV_B) $display("FAIL div2_first_rise: got %0d want %0d", n, DIV_B);
      else pass_cnt++;
      p = 0;
      while (bclk_b && p < 20) begin
         step();
         p++;
      end
      while (!bclk_b && p < 20) begin
         step();
         p++;
      end
      total_cnt++;
      if (p !== 2 * DIV_B) $display("FAIL div2_bclk_period: got %0d want %0d", p, 2 * DIV_B);
      else pass_cnt++;
      n = 0;
      while (!tick_b && n < 300) begin
         step();
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         p = 0;
         do begin
            step();
            p++;
         end while (!tick_b && p < 300);
         total_cnt++;
         if (p !== 64 * DIV_B) $display("FAIL div2_tick_spacing[%0d]: got %0d want %0d", i, p, 64 * DIV_B);
         else pass_cnt++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_word();
      test_underrun();
      test_back_to_back();
      test_accept_on_load();
      test_clk_div2();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule

// File: doc/i2s_tx.md
# i2s_tx

Mono-to-stereo I2S transmitter that sits at the output end of the audio chain, after the effects stage. It accepts one 16-bit signed sample per frame through a valid/ready handshake and serializes it to an external DAC on both channels in Philips I2S format. It also emits a one-cycle `sample_tick` at each frame load, which is the sample-rate strobe for upstream `enable` inputs. BCLK, LRCLK and SDATA are generated from the single system clock.

## Interface
- `CLK_DIV`, default 4: number of `clk` cycles per BCLK half-period, ≥2. Frame rate is clk / (64·CLK_DIV).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset. The block uses one clock, and reset is asynchronous and active-high.
- `din`  in  16  sample in two's complement; the same word is sent on left and right.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  holding buffer is empty; a transfer happens when `din_valid && din_ready` on a `clk` edge.
- `sample_tick`  out  1  one-cycle pulse on the frame-load cycle.
- `underrun`  out  1  one-cycle pulse on a frame-load cycle when the buffer was empty.
- `i2s_bclk`  out  1  bit clock.
- `i2s_lrclk`  out  1  word select: 0 = left, 1 = right.
- `i2s_sdata`  out  1  serial data, MSB first.

## Operation
- **Divider.** `div_cnt` counts 0..CLK_DIV-1. When it wraps, `i2s_bclk` toggles. A toggle from 1 to 0 is a *fall event*.
- **Slots.** `slot` counts 0..31 and advances on each fall event, wrapping from 31 to 0. Advancing to slot 0 is the *frame load*.
- **Frame load.**
  - If the buffer is full, the buffer word moves into `cur_word` and the buffer is emptied.
  - If the buffer is empty, `cur_word` keeps the previous word and `underrun` pulses.
  - `sample_tick` pulses on this cycle in both cases.
- **Data mapping** (on each fall event, for the slot being entered, with w = `cur_word`):
  - Slot 0 carries bit 0 of the previous frame's right word (one-BCLK I2S delay).
  - Slots 1..16 carry w[15]..w[0] on the left channel.
  - Slots 17..31 carry w[15]..w[1] on the right channel.
  - Bit w[0] of the right channel goes out in slot 0 of the next frame.
- **Word select.** `i2s_lrclk` is 0 in slots 0..15 and 1 in slots 16..31. It therefore changes one BCLK before each MSB.
- **Handshake.**
  - `din_ready` is the inverse of buffer-full.
  - A word accepted on the frame-load cycle itself is written to the buffer after the load decision, so it is sent in the next frame.
  - `din_ready` is independent of `din_valid` in the same cycle (no combinational path).
- **Width.** The sample is fixed at 16 bits. No arithmetic is performed on the data; it is passed through as given.

## Timing
- **Reset values.** While `rst` is high, and on the edge where it deasserts:
  - outputs: `i2s_bclk`=0, `i2s_lrclk`=0, `i2s_sdata`=0, `din_ready`=1, `sample_tick`=0, `underrun`=0;
  - internal state: `div_cnt`=0, `slot`=31, `cur_word`=0, previous-right-LSB=0, buffer empty.
- **Start-up after reset release.**
  - The first rising BCLK occurs CLK_DIV cycles after release.
  - The first fall event occurs 2·CLK_DIV cycles after release. It is the first frame load and enters slot 0.
- **Output registration.**
  - All outputs are registered.
  - `i2s_sdata` and `i2s_lrclk` change on the same `clk` edge as the fall event. They are therefore stable for CLK_DIV cycles before the next BCLK rise.
- **Latency.**
  - A word sitting in the buffer at a frame load has its left MSB on `i2s_sdata` 2·CLK_DIV cycles after the load.
  - An accepted word appears at the next frame load.
- **Mid-frame reset.** Reset aborts the frame immediately, drops the buffer contents and `cur_word`, and restarts with the start-up timing above. No partial word is replayed.
- **Throughput.** One sample per 64·CLK_DIV cycles. A producer driven by `sample_tick` never sees `din_ready`=0.

## Structure
- Shared `audio_pkg` holds:
  - `SAMPLE_W`=16;
  - `I2S_SLOTS`=32;
  - the `sample_t` typedef, used by the effect blocks as well.
- Sub-module `i2s_bclk_gen` contains the divider and BCLK toggle. It outputs `i2s_bclk` and a one-cycle `fall` strobe.
- Slot counter, buffer and shifter stay in `i2s_tx`.

## Test plan
- **Reset:** assert `rst` mid-frame.
  - All outputs at their reset values on the next edge.
  - First BCLK rise exactly CLK_DIV cycles after release.
- **Single word:** CLK_DIV=4, push 0xA5F0 before the first load.
  - Slots 1..16 read 1010010111110000; slots 17..31 read 101001011111000.
  - Next slot 0 reads 0.
  - `lrclk` low for 16 slots, then high for 16.
- **Underrun:** send 0x8001, then nothing.
  - Second frame repeats 0x8001 on both channels.
  - `underrun` pulses exactly once per starved frame, coincident with `sample_tick`.
- **Back-to-back:** send 0x1234 and 0xFFFF with `din_valid` held high.
  - `din_ready` drops after the first accept and returns high on the load cycle.
  - The second word is accepted and sent in the following frame; no word is lost or duplicated.
- **Accept on load cycle:** assert `din_valid` only on the `sample_tick` cycle with the buffer empty.
  - `underrun`=1 for the current frame.
  - The word is sent in the next frame.
- **CLK_DIV=2:**
  - BCLK period is 4 cycles; frame is 128 cycles.
  - `sample_tick` spacing is exactly 128 cycles over 10 frames.
